spi_dbg_arbiter: RTL



---
 rtl/spi_dbg_arbiter_if.sv | 22 ++
 rtl/spi_dbg_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/spi_dbg_arbiter_if.sv
// Requester-side handshake bundle for the SPI debug arbiter.
// One valid/ready pair and one data word per requester.
interface spi_dbg_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/spi_dbg_arbiter.sv
// Round-robin arbiter sharing one SPI mode-0 debug port between taps.
// Words are shifted MSB-first with one active-low chip select each.
module spi_dbg_arbiter #(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  spi_dbg_arbiter_if.slave req,
  output logic             spi_sck,
  output logic [N_REQ-1:0] spi_cs_n,
  output logic             spi_mosi,
  output logic             busy
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CMAX = (2*CLK_DIV > CS_GAP) ? 2*CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(2*CLK_DIV - 1);
  localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
  localparam logic [CW-1:0] HOLD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  =
    CW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic [CW-1:0]    cnt;

  logic             gnt_vld;
  logic [PW-1:0]    gnt;
  logic [WIDTH-1:0] gnt_data;
  int               idx;

  // Search starts just past the last winner and wraps.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt      = '0;
    gnt_data = '0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!gnt_vld && req.req_valid[idx]) begin
        gnt_vld  = 1'b1;
        gnt      = PW'(idx);
        gnt_data = req.req_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req.req_ready = '0;
    if (state == S_IDLE && gnt_vld)
      req.req_ready = N_REQ'(1) << gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= PW'(N_REQ - 1);
      shreg  <= '0;
      bitcnt <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            shreg  <= gnt_data;
            ptr    <= gnt;
            bitcnt <= BW'(WIDTH - 1);
            cnt    <= '0;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (bitcnt == '0) begin
              state <= S_HOLD;
            end else begin
              bitcnt <= bitcnt - 1'b1;
              shreg  <= shreg << 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= (CS_GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ptr holds the current grant for the whole frame.
  logic active;
  assign active   = (state == S_SHIFT) || (state == S_HOLD);
  assign spi_sck  = (state == S_SHIFT) && (cnt >= HALF);
  assign spi_cs_n = active ? ~(N_REQ'(1) << ptr) : '1;
  assign spi_mosi = active & shreg[WIDTH-1];
  assign busy     = (state != S_IDLE);

endmodule
